// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store initiator for a word-organised data memory; sub-word
//            stores use read-modify-write. Optional macro LSU_ALIGN_CHECK_EN
//            turns misaligned half/word accesses into error responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respRData,
    output logic        respError,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]  SZ_BYTE     = 2'b00;
    localparam logic [1:0]  SZ_HALF     = 2'b01;
    localparam logic [1:0]  SZ_WORD     = 2'b10;
    localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

    state_t      state_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        reqReady_q;
    logic        respValid_q;
    logic [31:0] respRData_q;
    logic        respError_q;
    logic [31:0] memAddress_q;
    logic [31:0] memWriteData_q;
    logic        memWrite_q;
    logic        memRead_q;

    logic [1:0]  lane_d;
    logic        reqErr_d;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] extract_d;
    logic [31:0] laneMask;
    logic [31:0] merged_d;

    // Accept-time decode: lane with misaligned low bits dropped, plus error check.
    always_comb begin
        lane_d   = reqAddr[1:0];
        reqErr_d = (reqSize == 2'b11) || ({2'b00, reqAddr[31:2]} >= C_MEM_WORDS);
        case (reqSize)
            SZ_HALF: begin
                lane_d = {reqAddr[1], 1'b0};
`ifdef LSU_ALIGN_CHECK_EN
                if (reqAddr[0]) reqErr_d = 1'b1;
`endif
            end
            SZ_WORD: begin
                lane_d = 2'b00;
`ifdef LSU_ALIGN_CHECK_EN
                if (reqAddr[1:0] != 2'b00) reqErr_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign shamt   = {lane_q, 3'b000};
    assign shifted = memReadData >> shamt;

    always_comb begin
        extract_d = memReadData;
        laneMask  = 32'hFFFF_FFFF;
        case (size_q)
            SZ_BYTE: begin
                extract_d = {{24{signed_q & shifted[7]}}, shifted[7:0]};
                laneMask  = 32'h0000_00FF << shamt;
            end
            SZ_HALF: begin
                extract_d = {{16{signed_q & shifted[15]}}, shifted[15:0]};
                laneMask  = 32'h0000_FFFF << shamt;
            end
            default: ;
        endcase
        merged_d = (memReadData & ~laneMask) | ((wdata_q << shamt) & laneMask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            write_q        <= 1'b0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            lane_q         <= 2'b00;
            wdata_q        <= 32'd0;
            reqReady_q     <= 1'b1;
            respValid_q    <= 1'b0;
            respRData_q    <= 32'd0;
            respError_q    <= 1'b0;
            memAddress_q   <= 32'd0;
            memWriteData_q <= 32'd0;
            memWrite_q     <= 1'b0;
            memRead_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (reqValid && reqReady_q) begin
                        write_q    <= reqWrite;
                        size_q     <= reqSize;
                        signed_q   <= reqSigned;
                        lane_q     <= lane_d;
                        wdata_q    <= reqWData;
                        reqReady_q <= 1'b0;
                        if (reqErr_d) begin
                            respValid_q <= 1'b1;
                            respError_q <= 1'b1;
                            respRData_q <= 32'd0;
                            state_q     <= S_RESP;
                        end else begin
                            memAddress_q <= {2'b00, reqAddr[31:2]};
                            if (reqWrite && (reqSize == SZ_WORD)) begin
                                memWrite_q     <= 1'b1;
                                memWriteData_q <= reqWData;
                                state_q        <= S_WRITE;
                            end else begin
                                memRead_q <= 1'b1;
                                state_q   <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    memRead_q <= 1'b0;
                    if (write_q) begin
                        memWrite_q     <= 1'b1;
                        memWriteData_q <= merged_d;
                        state_q        <= S_WRITE;
                    end else begin
                        respRData_q <= extract_d;
                        respValid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_WRITE: begin
                    memWrite_q  <= 1'b0;
                    respRData_q <= 32'd0;
                    respValid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (respReady) begin
                        respValid_q <= 1'b0;
                        respError_q <= 1'b0;
                        respRData_q <= 32'd0;
                        reqReady_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reqReady     = reqReady_q;
    assign respValid    = respValid_q;
    assign respRData    = respRData_q;
    assign respError    = respError_q;
    assign memAddress   = memAddress_q;
    assign memWriteData = memWriteData_q;
    assign memWrite     = memWrite_q;
    assign memRead      = memRead_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWData;
    logic        respValid, respReady, respError;
    logic [31:0] respRData;
    logic [31:0] memAddress, memWriteData, memReadData;
    logic        memWrite, memRead;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWData(reqWData),
        .respValid(respValid), .respReady(respReady), .respRData(respRData),
        .respError(respError),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memWrite(memWrite), .memRead(memRead), .memReadData(memReadData)
    );

    logic [31:0] mem [0:255];
    assign memReadData = mem[memAddress[7:0]];
    always @(posedge clk) if (memWrite) mem[memAddress[7:0]] <= memWriteData;

    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;
    always @(negedge clk) begin
        if (memWrite) begin
            wr_cnt++;
            last_waddr = memAddress;
            last_wdata = memWriteData;
        end
        if (memRead) rd_cnt++;
        if (memWrite && memRead) both_cnt++;
    end

    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    resp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_rds, input int exp_wrs);
        int    r0 = rd_cnt;
        int    w0 = wr_cnt;
        bit    got = 0;
        resp_t e;
        sb_q.push_back('{exp_rd, exp_err});
        @(negedge clk);
        reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg;
        reqAddr = addr; reqWData = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            if (reqReady) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            reqValid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk);
        #1 reqValid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (respValid) got = 1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            check({tag, "_resp_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_rdata"}, respRData, e.rdata);
        check({tag, "_err"}, 32'(respError), 32'(e.err));
        @(posedge clk);
        #1;
        check({tag, "_reads"}, 32'(rd_cnt - r0), 32'(exp_rds));
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wrs));
    endtask

    initial begin
        logic [31:0] exp_word;
        logic [7:0]  bval;
        logic [31:0] stall_exp;
        bit          got;
        int          w0;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqSigned = 1'b0; reqAddr = 32'd0; reqWData = 32'd0; respReady = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_reqReady", 32'(reqReady), 32'd1);
        check("rst_memWrite", 32'(memWrite), 32'd0);
        check("rst_memRead", 32'(memRead), 32'd0);
        check("rst_respValid", 32'(respValid), 32'd0);
        check("rst_respRData", respRData, 32'd0);
        check("rst_respError", 32'(respError), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_req("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'd0, 0, 0, 1);
        check("sw10_waddr", last_waddr, 32'd4);
        check("sw10_wdata", last_wdata, 32'hDEADBEEF);
        do_req("lw10", 0, 2'b10, 0, 32'h10, 32'd0, 32'hDEADBEEF, 0, 1, 0);

        do_req("sb11", 1, 2'b00, 0, 32'h11, 32'h000000A5, 32'd0, 0, 1, 1);
        check("sb11_wdata", last_wdata, 32'hDEADA5EF);
        do_req("lb11", 0, 2'b00, 1, 32'h11, 32'd0, 32'hFFFFFFA5, 0, 1, 0);
        do_req("lbu11", 0, 2'b00, 0, 32'h11, 32'd0, 32'h000000A5, 0, 1, 0);

        do_req("sh12", 1, 2'b01, 0, 32'h12, 32'h00008001, 32'd0, 0, 1, 1);
        check("sh12_wdata", last_wdata, 32'h8001A5EF);
        do_req("lh12", 0, 2'b01, 1, 32'h12, 32'd0, 32'hFFFF8001, 0, 1, 0);
        do_req("lhu12", 0, 2'b01, 0, 32'h12, 32'd0, 32'h00008001, 0, 1, 0);

        do_req("lw_oor", 0, 2'b10, 0, 32'h400, 32'd0, 32'd0, 1, 0, 0);
        do_req("sw_oor", 1, 2'b10, 0, 32'h400, 32'h12345678, 32'd0, 1, 0, 0);
        do_req("sz11", 0, 2'b11, 0, 32'h10, 32'd0, 32'd0, 1, 0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        do_req("lw13", 0, 2'b10, 0, 32'h13, 32'd0, 32'd0, 1, 0, 0);
        do_req("lh13", 0, 2'b01, 1, 32'h13, 32'd0, 32'd0, 1, 0, 0);
`else
        do_req("lw13", 0, 2'b10, 0, 32'h13, 32'd0, 32'h8001A5EF, 0, 1, 0);
        do_req("lh13", 0, 2'b01, 1, 32'h13, 32'd0, 32'hFFFF8001, 0, 1, 0);
`endif

        // Build a word one byte lane at a time, then read it back whole and by halves.
        exp_word = 32'd0;
        do_req("sw20", 1, 2'b10, 0, 32'h20, 32'd0, 32'd0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            bval = 8'h3C + 8'(i * 8'h5A);
            exp_word[i*8 +: 8] = bval;
            do_req("sb_lane", 1, 2'b00, 0, 32'h20 + 32'(i), {24'hFFFFFF, bval},
                   32'd0, 0, 1, 1);
            check("sb_lane_wdata", last_wdata, exp_word);
        end
        do_req("lw20", 0, 2'b10, 0, 32'h20, 32'd0, exp_word, 0, 1, 0);
        do_req("lh22", 0, 2'b01, 1, 32'h22, 32'd0,
               {{16{exp_word[31]}}, exp_word[31:16]}, 0, 1, 0);
        do_req("lhu20", 0, 2'b01, 0, 32'h20, 32'd0, {16'd0, exp_word[15:0]}, 0, 1, 0);

        // Response back-pressure: output must hold while respReady is low.
        stall_exp = 32'h8001A5EF;
        sb_q.push_back('{stall_exp, 1'b0});
        @(negedge clk);
        respReady = 1'b0;
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0;
        reqAddr = 32'h10;
        @(posedge clk);
        #1 reqValid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (respValid) got = 1;
        end
        if (!got) check("stall_resp_timeout", 32'd0, 32'd1);
        reqValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_respValid", 32'(respValid), 32'd1);
            check("stall_rdata", respRData, sb_q[0].rdata);
            check("stall_reqReady", 32'(reqReady), 32'd0);
        end
        reqValid = 1'b0;
        respReady = 1'b1;
        void'(sb_q.pop_front());
        @(posedge clk);
        #1;

        // Reset while a read-modify-write store sits in READ.
        do_req("sw30", 1, 2'b10, 0, 32'h30, 32'h11223344, 32'd0, 0, 0, 1);
        w0 = wr_cnt;
        @(negedge clk);
        check("rstmid_ready", 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqAddr = 32'h30;
        reqWData = 32'h000000FF;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        check("rstmid_in_read", 32'(memRead), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_memWrite", 32'(memWrite), 32'd0);
        check("rstmid_memRead", 32'(memRead), 32'd0);
        check("rstmid_reqReady", 32'(reqReady), 32'd1);
        check("rstmid_respValid", 32'(respValid), 32'd0);
        check("rstmid_nowrite", 32'(wr_cnt - w0), 32'd0);
        do_req("lw30", 0, 2'b10, 0, 32'h30, 32'd0, 32'h11223344, 0, 1, 0);

        check("rw_overlap", 32'(both_cnt), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
